bullet_hit_judge: RTL and testbench



---
 rtl/bullet_hit_judge_if.sv | 33 +++
 rtl/bullet_hit_judge.sv | 206 ++++++++++++++++++++
 tb/tb_bullet_hit_judge.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bullet_hit_judge_if.sv
`default_nettype none
// ============================================================================
// bullet_hit_judge_if : game, enemy-link and pixel signals of bullet_hit_judge
// Revision 1.0
// ============================================================================
interface bullet_hit_judge_if;
  logic        move_tick;
  logic        fire;
  logic [9:0]  player_x;
  logic [9:0]  player_y;
  logic [9:0]  enemy_x;
  logic [9:0]  enemy_y;
  logic        enemyplane_exist;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        boom;
  logic        bullet_en;
  logic [11:0] bullet_rgb;
  logic [7:0]  hit_count;

  modport master (
    output move_tick, fire, player_x, player_y, enemy_x, enemy_y,
           enemyplane_exist, x, y,
    input  boom, bullet_en, bullet_rgb, hit_count
  );

  modport slave (
    input  move_tick, fire, player_x, player_y, enemy_x, enemy_y,
           enemyplane_exist, x, y,
    output boom, bullet_en, bullet_rgb, hit_count
  );
endinterface
`default_nettype wire

// File: rtl/bullet_hit_judge.sv
`default_nettype none
// ============================================================================
// bullet_hit_judge : player bullet launch/move, enemy hit check, boom hold,
//                    pixel overlay. Optional macro BULLET_AUTOFIRE_EN.
// Revision 1.0
// ============================================================================
module bullet_hit_judge #(
  parameter int N_BULLET    = 4,
  parameter int BULLET_W    = 4,
  parameter int BULLET_H    = 10,
  parameter int BULLET_STEP = 4,
  parameter int ENEMY_W     = 50,
  parameter int ENEMY_H     = 50,
  parameter int BOOM_HOLD   = 300,
  parameter int FIRE_GAP    = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  bullet_hit_judge_if.slave bus
);

  localparam int TMR_W = $clog2(BOOM_HOLD);
  localparam int CD_W  = $clog2(FIRE_GAP + 1);

  localparam logic [10:0] BW11 = 11'(BULLET_W);
  localparam logic [10:0] BH11 = 11'(BULLET_H);
  localparam logic [10:0] EW11 = 11'(ENEMY_W);
  localparam logic [10:0] EH11 = 11'(ENEMY_H);
  localparam logic [9:0]  BH10 = 10'(BULLET_H);
  localparam logic [9:0]  STEP10 = 10'(BULLET_STEP);
  localparam logic [9:0]  X_OFF = 10'(25 - BULLET_W / 2);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BOOM_HOLD - 1);
  localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'(FIRE_GAP - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BOOM = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               boom_q, boom_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CD_W-1:0]    cd_q, cd_d;
  logic [7:0]         hit_count_q, hit_count_d;

  logic [N_BULLET-1:0] valid_q, valid_d;
  logic [9:0]          bx_q [N_BULLET];
  logic [9:0]          bx_d [N_BULLET];
  logic [9:0]          by_q [N_BULLET];
  logic [9:0]          by_d [N_BULLET];

  logic [N_BULLET-1:0] ovl;
  logic [N_BULLET-1:0] pix;
  logic [N_BULLET-1:0] hit_mask;
  logic [N_BULLET-1:0] free_mask;
  logic                hit_any;
  logic                free_any;
  logic                hit_en;
  logic                fire_eff;
  logic                launch;

`ifdef BULLET_AUTOFIRE_EN
  assign fire_eff = 1'b1;
`else
  assign fire_eff = bus.fire;
`endif

  // All box comparisons are done in 11 bits so x+width never wraps.
  logic [10:0] ex_ext, ey_ext, px_ext, py_ext;
  assign ex_ext = {1'b0, bus.enemy_x};
  assign ey_ext = {1'b0, bus.enemy_y};
  assign px_ext = {1'b0, bus.x};
  assign py_ext = {1'b0, bus.y};

  for (genvar i = 0; i < N_BULLET; i++) begin : g_slot
    logic [10:0] bx_ext, by_ext;
    assign bx_ext = {1'b0, bx_q[i]};
    assign by_ext = {1'b0, by_q[i]};
    assign ovl[i] = valid_q[i]
                  && (bx_ext < ex_ext + EW11) && (bx_ext + BW11 > ex_ext)
                  && (by_ext < ey_ext + EH11) && (by_ext + BH11 > ey_ext);
    assign pix[i] = valid_q[i]
                  && (px_ext >= bx_ext) && (px_ext < bx_ext + BW11)
                  && (py_ext >= by_ext) && (py_ext < by_ext + BH11);
  end

  assign hit_en = (state_q == IDLE) && bus.enemyplane_exist;

  // Lowest-index selection for both the hitting slot and the launch target.
  always_comb begin
    hit_mask  = '0;
    free_mask = '0;
    hit_any   = 1'b0;
    free_any  = 1'b0;
    for (int i = 0; i < N_BULLET; i++) begin
      if (hit_en && ovl[i] && !hit_any) begin
        hit_mask[i] = 1'b1;
        hit_any     = 1'b1;
      end
      if (!valid_q[i] && !free_any) begin
        free_mask[i] = 1'b1;
        free_any     = 1'b1;
      end
    end
  end

  assign launch = fire_eff && (cd_q == '0) && free_any && (bus.player_y >= BH10);

  // Next slot state; only slots invalid before the tick can be launch targets,
  // so a slot freed this tick is not reused until the next one.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < N_BULLET; i++) begin
      bx_d[i] = bx_q[i];
      by_d[i] = by_q[i];
      if (valid_q[i]) begin
        if (hit_mask[i]) begin
          valid_d[i] = 1'b0;
        end else if (by_q[i] < STEP10) begin
          valid_d[i] = 1'b0;
        end else begin
          by_d[i] = by_q[i] - STEP10;
        end
      end else if (launch && free_mask[i]) begin
        valid_d[i] = 1'b1;
        bx_d[i]    = bus.player_x + X_OFF;
        by_d[i]    = bus.player_y - BH10;
      end
    end
  end

  always_comb begin
    cd_d = cd_q;
    if (launch) begin
      cd_d = CD_LOAD;
    end else if (cd_q != '0) begin
      cd_d = cd_q - CD_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    boom_d      = boom_q;
    timer_d     = timer_q;
    hit_count_d = hit_count_q;
    case (state_q)
      IDLE: begin
        boom_d = 1'b0;
        if (hit_any) begin
          state_d = BOOM;
          boom_d  = 1'b1;
          timer_d = '0;
          if (hit_count_q != 8'hFF) begin
            hit_count_d = hit_count_q + 8'd1;
          end
        end
      end
      BOOM: begin
        if (timer_q == TMR_LAST) begin
          state_d = IDLE;
          boom_d  = 1'b0;
        end else begin
          boom_d  = 1'b1;
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        boom_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      boom_q      <= 1'b0;
      timer_q     <= '0;
      cd_q        <= '0;
      hit_count_q <= '0;
      valid_q     <= '0;
      for (int i = 0; i < N_BULLET; i++) begin
        bx_q[i] <= '0;
        by_q[i] <= '0;
      end
    end else if (bus.move_tick) begin
      state_q     <= state_d;
      boom_q      <= boom_d;
      timer_q     <= timer_d;
      cd_q        <= cd_d;
      hit_count_q <= hit_count_d;
      valid_q     <= valid_d;
      for (int i = 0; i < N_BULLET; i++) begin
        bx_q[i] <= bx_d[i];
        by_q[i] <= by_d[i];
      end
    end
  end

  assign bus.boom       = boom_q;
  assign bus.bullet_en  = |pix;
  assign bus.bullet_rgb = (|pix) ? 12'hFF0 : 12'h000;
  assign bus.hit_count  = hit_count_q;

endmodule
`default_nettype wire

// File: tb/tb_bullet_hit_judge.sv
`default_nettype none
// ============================================================================
// tb_bullet_hit_judge : directed self-checking bench for bullet_hit_judge
// Revision 1.0
// ============================================================================
module tb_bullet_hit_judge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  bullet_hit_judge_if b ();

  bullet_hit_judge dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    b.move_tick = 1'b1;
    @(negedge clk);
    b.move_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic probe(input int px, input int py, output logic en);
    b.x = 10'(px);
    b.y = 10'(py);
    #1;
    en = b.bullet_en;
  endtask

  // Number of distinct vertical bullet runs crossing column px.
  task automatic count_column(input int px, output int n);
    logic en;
    logic prev;
    n = 0;
    prev = 1'b0;
    for (int yy = 0; yy < 480; yy++) begin
      probe(px, yy, en);
      if (en && !prev) n++;
      prev = en;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic en;
    b.move_tick = 1'b0; b.fire = 1'b0; b.enemyplane_exist = 1'b0;
    b.player_x = 10'd300; b.player_y = 10'd430;
    b.enemy_x = 10'd0; b.enemy_y = 10'd0; b.x = 10'd0; b.y = 10'd0;
    do_reset();
    n_cmp++;
    if (b.boom !== 1'b0) begin n_bad++; $display("FAIL reset_boom got %b want 0", b.boom); end
    n_cmp++;
    if (b.hit_count !== 8'd0) begin n_bad++; $display("FAIL reset_hit_count got %0d want 0", b.hit_count); end
    probe(0, 0, en);
    n_cmp++;
    if (en !== 1'b0 || b.bullet_rgb !== 12'h000) begin
      n_bad++; $display("FAIL reset_pixel got en=%b rgb=%h want 0/000", en, b.bullet_rgb);
    end
  endtask

  task automatic test_launch_move();
    logic en;
    do_reset();
    b.player_x = 10'd300; b.player_y = 10'd430; b.enemyplane_exist = 1'b0;
    b.fire = 1'b1;
    tick();
    b.fire = 1'b0;
    probe(323, 420, en);
    n_cmp++;
    if (en !== 1'b1 || b.bullet_rgb !== 12'hFF0) begin
      n_bad++; $display("FAIL launch_topleft got en=%b rgb=%h want 1/ff0", en, b.bullet_rgb);
    end
    probe(326, 429, en);
    n_cmp++;
    if (en !== 1'b1) begin n_bad++; $display("FAIL launch_botright got %b want 1", en); end
    probe(327, 420, en);
    n_cmp++;
    if (en !== 1'b0) begin n_bad++; $display("FAIL launch_right_edge got %b want 0", en); end
    probe(323, 419, en);
    n_cmp++;
    if (en !== 1'b0) begin n_bad++; $display("FAIL launch_above got %b want 0", en); end
    ticks(5);
    probe(323, 400, en);
    n_cmp++;
    if (en !== 1'b1) begin n_bad++; $display("FAIL move_top got %b want 1", en); end
    probe(327, 400, en);
    n_cmp++;
    if (en !== 1'b0 || b.bullet_rgb !== 12'h000) begin
      n_bad++; $display("FAIL move_right_edge got en=%b rgb=%h want 0/000", en, b.bullet_rgb);
    end
    probe(323, 410, en);
    n_cmp++;
    if (en !== 1'b0) begin n_bad++; $display("FAIL move_bottom_edge got %b want 0", en); end
  endtask

  task automatic test_fire_gap();
    int  n;
    logic en;
    bit  refilled;
    do_reset();
    b.player_x = 10'd300; b.player_y = 10'd430; b.enemyplane_exist = 1'b0;
    b.fire = 1'b1;
    for (int t = 0; t <= 106; t++) begin
      tick();
      if (t == 0 || t == 15 || t == 16 || t == 48 || t == 64 || t == 105 || t == 106) begin
        count_column(323, n);
        n_cmp++;
        if (t == 0 && n != 1) begin n_bad++; $display("FAIL gap_t0 got %0d want 1", n); end
        if (t == 15 && n != 1) begin n_bad++; $display("FAIL gap_t15 got %0d want 1", n); end
        if (t == 16 && n != 2) begin n_bad++; $display("FAIL gap_t16 got %0d want 2", n); end
        if (t == 48 && n != 4) begin n_bad++; $display("FAIL gap_t48 got %0d want 4", n); end
        if (t == 64 && n != 4) begin n_bad++; $display("FAIL gap_t64_full got %0d want 4", n); end
        if (t == 105 && n != 4) begin n_bad++; $display("FAIL gap_t105 got %0d want 4", n); end
        if (t == 106 && n != 3) begin n_bad++; $display("FAIL gap_t106_freed got %0d want 3", n); end
      end
      if (t == 16) begin
        probe(323, 356, en);
        n_cmp++;
        if (en !== 1'b1) begin n_bad++; $display("FAIL gap_first_pos got %b want 1", en); end
      end
    end
    refilled = 1'b0;
    for (int t = 0; t < 40 && !refilled; t++) begin
      tick();
      count_column(323, n);
      if (n == 4) refilled = 1'b1;
    end
    n_cmp++;
    if (!refilled) begin n_bad++; $display("FAIL gap_refill got %0d bullets want 4", n); end
    b.fire = 1'b0;
  endtask

  task automatic test_hit_and_hold();
    logic en;
    bit   boom_ok;
    do_reset();
    b.enemy_x = 10'd80; b.enemy_y = 10'd0; b.enemyplane_exist = 1'b0;
    b.player_x = 10'd77; b.player_y = 10'd60;
    b.fire = 1'b1;
    tick();
    b.fire = 1'b0;
    b.enemyplane_exist = 1'b1;
    tick();
    probe(100, 46, en);
    n_cmp++;
    if (b.boom !== 1'b0 || b.hit_count !== 8'd0 || en !== 1'b1) begin
      n_bad++; $display("FAIL hit_edge_miss got boom=%b hc=%0d en=%b want 0/0/1", b.boom, b.hit_count, en);
    end
    tick();
    probe(100, 42, en);
    n_cmp++;
    if (b.boom !== 1'b1 || b.hit_count !== 8'd1 || en !== 1'b0) begin
      n_bad++; $display("FAIL hit_first got boom=%b hc=%0d en=%b want 1/1/0", b.boom, b.hit_count, en);
    end
    b.enemyplane_exist = 1'b0;
    b.player_y = 10'd50;
    boom_ok = 1'b1;
    for (int k = 1; k <= 299; k++) begin
      if (k == 21) begin b.fire = 1'b1; b.enemyplane_exist = 1'b1; end
      tick();
      if (k == 21) b.fire = 1'b0;
      if (k == 40) b.enemyplane_exist = 1'b0;
      if (b.boom !== 1'b1) boom_ok = 1'b0;
      if (k == 25) begin
        probe(100, 24, en);
        n_cmp++;
        if (en !== 1'b1) begin n_bad++; $display("FAIL boom_passthrough got %b want 1", en); end
      end
    end
    n_cmp++;
    if (!boom_ok) begin n_bad++; $display("FAIL boom_hold got dropped want held 299 ticks"); end
    n_cmp++;
    if (b.hit_count !== 8'd1) begin n_bad++; $display("FAIL boom_no_rehit got %0d want 1", b.hit_count); end
    tick();
    n_cmp++;
    if (b.boom !== 1'b0) begin n_bad++; $display("FAIL boom_fall got %b want 0", b.boom); end
  endtask

  task automatic test_double_hit();
    logic en0, en1, en2;
    do_reset();
    b.enemyplane_exist = 1'b0; b.enemy_x = 10'd80; b.enemy_y = 10'd300;
    b.player_x = 10'd77; b.player_y = 10'd400;
    b.fire = 1'b1;
    tick();
    b.fire = 1'b0;
    ticks(15);
    b.player_x = 10'd97; b.player_y = 10'd336; b.fire = 1'b1;
    tick();
    b.fire = 1'b0;
    probe(100, 326, en0);
    probe(120, 326, en1);
    probe(104, 326, en2);
    n_cmp++;
    if (en0 !== 1'b1 || en1 !== 1'b1 || en2 !== 1'b0) begin
      n_bad++; $display("FAIL double_setup got %b%b%b want 110", en0, en1, en2);
    end
    b.enemyplane_exist = 1'b1;
    tick();
    b.enemyplane_exist = 1'b0;
    probe(100, 326, en0);
    probe(100, 322, en1);
    probe(120, 322, en2);
    n_cmp++;
    if (en0 !== 1'b0 || en1 !== 1'b0 || en2 !== 1'b1) begin
      n_bad++; $display("FAIL double_slots got %b%b%b want 001", en0, en1, en2);
    end
    n_cmp++;
    if (b.hit_count !== 8'd1 || b.boom !== 1'b1) begin
      n_bad++; $display("FAIL double_count got hc=%0d boom=%b want 1/1", b.hit_count, b.boom);
    end
  endtask

  task automatic test_reset_mid_boom();
    logic en;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    probe(120, 322, en);
    n_cmp++;
    if (b.boom !== 1'b0 || b.hit_count !== 8'd0 || en !== 1'b0) begin
      n_bad++; $display("FAIL async_reset got boom=%b hc=%0d en=%b want 0/0/0", b.boom, b.hit_count, en);
    end
    @(negedge clk);
    rst = 1'b0;
    b.fire = 1'b0; b.enemyplane_exist = 1'b0;
    b.player_x = 10'd77; b.player_y = 10'd430;
    tick();
    probe(100, 420, en);
    n_cmp++;
`ifdef BULLET_AUTOFIRE_EN
    if (en !== 1'b1) begin n_bad++; $display("FAIL autofire_launch got %b want 1", en); end
`else
    if (en !== 1'b0) begin n_bad++; $display("FAIL no_fire_no_launch got %b want 0", en); end
`endif
  endtask

  initial begin
    test_reset();
    test_launch_move();
    test_fire_gap();
    test_hit_and_hold();
    test_double_hit();
    test_reset_mid_boom();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
